// File: rtl/alu_arbiter.sv
// Two-requester arbiter/sequencer in front of one shared combinational add/sub ALU.
// Define ALU_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module alu_arbiter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,

    output logic [1:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_r,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_r,
    output logic [15:0]      op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    logic   winner;
    logic   accept;

`ifdef ALU_ARB_ROUND_ROBIN_EN
    logic last_grant;

    // Under contention the requester that was not granted last time wins.
    always_comb begin
        winner = 1'b0;
        if (req0_valid && req1_valid) begin
            winner = ~last_grant;
        end else if (req1_valid) begin
            winner = 1'b1;
        end
    end
`else
    always_comb begin
        winner = ~req0_valid;
    end
`endif

    assign req0_ready = (state == IDLE) && req0_valid && (winner == 1'b0);
    assign req1_ready = (state == IDLE) && req1_valid && (winner == 1'b1);
    assign accept     = req0_ready || req1_ready;

    // The operand registers drive the ALU directly, so alu_* are the latched operands.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            alu_op    <= 2'd0;
            alu_a     <= '0;
            alu_b     <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_r     <= '0;
            op_count  <= 16'd0;
`ifdef ALU_ARB_ROUND_ROBIN_EN
            last_grant <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        alu_op <= winner ? req1_op : req0_op;
                        alu_a  <= winner ? req1_a  : req0_a;
                        alu_b  <= winner ? req1_b  : req0_b;
                        rsp_id <= winner;
`ifdef ALU_ARB_ROUND_ROBIN_EN
                        last_grant <= winner;
`endif
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_r     <= alu_r;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        op_count  <= op_count + 16'd1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with a behavioural add/sub ALU model.
// Honours ALU_ARB_ROUND_ROBIN_EN for the contention expectations.
module tb_alu_arbiter;

    localparam int WIDTH = 16;

    logic             clk;
    logic             reset;
    logic             req0_valid, req1_valid;
    logic             req0_ready, req1_ready;
    logic [1:0]       req0_op, req1_op;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [1:0]       alu_op;
    logic [WIDTH-1:0] alu_a, alu_b, alu_r;
    logic             rsp_valid, rsp_ready, rsp_id;
    logic [WIDTH-1:0] rsp_r;
    logic [15:0]      op_count;

    int assert_count = 0;
    int fail_count   = 0;

    alu_arbiter #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_r(alu_r),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_r(rsp_r), .op_count(op_count)
    );

    // Shared add_sub_logic stand-in: op 0 adds, op 1 subtracts, others yield 0.
    assign alu_r = (alu_op == 2'd0) ? alu_a + alu_b :
                   (alu_op == 2'd1) ? alu_a - alu_b : '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert_count++;
        assert (obs === exp) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One complete transaction with rsp_ready held high.
    task automatic do_op(input string tag, input bit id, input logic [1:0] op,
                         input logic [15:0] a, input logic [15:0] b, input logic [15:0] exp_r);
        @(negedge clk);
        rsp_ready = 1'b1;
        if (id) begin
            req1_op = op; req1_a = a; req1_b = b; req1_valid = 1'b1;
        end else begin
            req0_op = op; req0_a = a; req0_b = b; req0_valid = 1'b1;
        end
        #1;
        check_output({tag, "_ready0"}, req0_ready, !id);
        check_output({tag, "_ready1"}, req1_ready, id);
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check_output({tag, "_alu_a"}, alu_a, a);
        check_output({tag, "_alu_b"}, alu_b, b);
        check_output({tag, "_alu_op"}, alu_op, op);
        check_output({tag, "_exec_valid"}, rsp_valid, 0);
        @(negedge clk);
        check_output({tag, "_rsp_valid"}, rsp_valid, 1);
        check_output({tag, "_rsp_id"}, rsp_id, id);
        check_output({tag, "_rsp_r"}, rsp_r, exp_r);
        @(negedge clk);
        check_output({tag, "_done_valid"}, rsp_valid, 0);
    endtask

    task automatic wait_rsp(input string tag);
        int k = 0;
        while (!rsp_valid && k < 12) begin
            @(negedge clk);
            k++;
        end
        check_output({tag, "_timeout"}, rsp_valid, 1);
    endtask

    initial begin
        reset = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_op = 2'd0; req1_op = 2'd0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        rsp_ready = 1'b0;

        repeat (2) @(negedge clk);
        check_output("reset_rsp_valid", rsp_valid, 0);
        check_output("reset_op_count", op_count, 0);
        check_output("reset_rsp_r", rsp_r, 0);
        reset = 1'b0;

        $display("[TB] single add and subtract wrap");
        do_op("add", 1'b0, 2'd0, 16'd2, 16'd3, 16'd5);
        check_output("add_count", op_count, 1);
        do_op("sub", 1'b1, 2'd1, 16'd100, 16'd200, 16'hff9c);
        check_output("sub_count", op_count, 2);

        $display("[TB] reset during EXEC");
        @(negedge clk);
        req0_op = 2'd0; req0_a = 16'd1; req0_b = 16'd1; req0_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        reset = 1'b1;
        #1;
        check_output("rst_rsp_valid", rsp_valid, 0);
        check_output("rst_ready0", req0_ready, 0);
        check_output("rst_ready1", req1_ready, 0);
        check_output("rst_op_count", op_count, 0);
        check_output("rst_alu_a", alu_a, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_output("rst_no_rsp", rsp_valid, 0);
        check_output("rst_no_count", op_count, 0);

        $display("[TB] contention");
        req0_op = 2'd0; req0_a = 16'd100; req0_b = 16'd200;
        req1_op = 2'd1; req1_a = 16'd10;  req1_b = 16'd5;
        req0_valid = 1'b1; req1_valid = 1'b1;
        rsp_ready = 1'b1;
        #1;
        check_output("cont_first_ready0", req0_ready, 1);
        check_output("cont_first_ready1", req1_ready, 0);
        for (int i = 0; i < 3; i++) begin
            bit exp_id;
`ifdef ALU_ARB_ROUND_ROBIN_EN
            exp_id = (i == 1);
`else
            exp_id = 1'b0;
`endif
            @(negedge clk);
            wait_rsp("cont");
            check_output("cont_id", rsp_id, exp_id);
            check_output("cont_r", rsp_r, exp_id ? 16'd5 : 16'd300);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        check_output("cont_count", op_count, 3);

        $display("[TB] backpressure");
        rsp_ready = 1'b0;
        req0_op = 2'd0; req0_a = 16'd7; req0_b = 16'd8; req0_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_op = 2'd1; req1_a = 16'd9; req1_b = 16'd4; req1_valid = 1'b1;
        @(negedge clk);
        wait_rsp("bp");
        for (int i = 0; i < 5; i++) begin
            check_output("bp_rsp_r", rsp_r, 16'd15);
            check_output("bp_rsp_valid", rsp_valid, 1);
            check_output("bp_ready1", req1_ready, 0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check_output("bp_after_ready1", req1_ready, 1);
        check_output("bp_after_count", op_count, 4);
        @(posedge clk);
        @(negedge clk);
        req1_valid = 1'b0;
        @(negedge clk);
        check_output("bp_req1_id", rsp_id, 1);
        check_output("bp_req1_r", rsp_r, 16'd5);
        @(negedge clk);

        $display("[TB] counter wrap");
        force dut.op_count = 16'hfffe;
        #1;
        release dut.op_count;
        do_op("wrap1", 1'b0, 2'd0, 16'd1, 16'd1, 16'd2);
        check_output("wrap_ffff", op_count, 16'hffff);
        do_op("wrap2", 1'b1, 2'd0, 16'hffff, 16'd2, 16'd1);
        check_output("wrap_zero", op_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
